obuffer_deskew: RTL and testbench
=================================

OBUFFER_DESKEW -- requirements
Module: obuffer_deskew

Interface
REQ-001 Parameter: LANE_W, default 8, bit width of one array output lane.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 OCOL_VALID  input  4  per-column capture strobe from array bottom edge; column j arrives one cycle after column j-1.
REQ-005 OROW_i  input  4*LANE_W  array outputs; lane j = bits [(4-j)*LANE_W-1 -: LANE_W], column 0 in the MSB lane.
REQ-006 ODST_i  input  4  destination tag for the tile being collected.
REQ-007 OREADY_i  input  1  downstream sink accepts the current word.
REQ-008 OWord  output  4*LANE_W  one de-skewed result row: {col0,col1,col2,col3}.
REQ-009 OVALID_o  output  1  OWord/ORIDX_o/ODST_o are valid.
REQ-010 ORIDX_o  output  2  row index of OWord, 0..3.
REQ-011 ODST_o  output  4  tag latched for the current tile.
REQ-012 BUSY_o  output  1  high in COLLECT or DRAIN.
REQ-013 OVF_o  output  1  sticky overflow/protocol error flag.

Function
REQ-014 FSM states IDLE, COLLECT, DRAIN.
REQ-015 IDLE->COLLECT on OCOL_VALID[0]=1; that cycle captures data and latches ODST_i into ODST_o.
REQ-016 Per column j: 4-entry store plus 3-bit count; on OCOL_VALID[j] in IDLE/COLLECT with count[j]<4, write lane j at entry count[j], then count[j]+1.
REQ-017 First capture in a column is row 0, fourth is row 3.
REQ-018 COLLECT->DRAIN in the cycle after all four counts equal 4; DRAIN entered one cycle after column 3's fourth capture.
REQ-019 OVALID_o high throughout DRAIN; ORIDX_o starts at 0; OWord = row ORIDX_o of all four columns.
REQ-020 Handshake: word transfers when OVALID_o & OREADY_i; ORIDX_o increments only on transfer; OWord, ORIDX_o, ODST_o stable while OVALID_o & !OREADY_i.
REQ-021 Transfer with ORIDX_o=3: next state IDLE, all counts cleared, ORIDX_o=0, OVALID_o=0.
REQ-022 Best-case latency: row 0 visible 1 cycle after last capture; 4 words over 4 consecutive cycles when OREADY_i held high.
REQ-023 OCOL_VALID[j] in DRAIN, or with count[j]=4 in COLLECT: data dropped, OVF_o set; state unaffected.
REQ-024 OCOL_VALID[j] (j>0) in IDLE: OVF_o set, data dropped.
REQ-025 OCOL_VALID in the same cycle as the final DRAIN transfer: treated as DRAIN (dropped, OVF_o set).
REQ-026 OVF_o cleared only by reset.
REQ-027 OWord = 0 whenever OVALID_o=0.

Reset
REQ-028 RSTN low: state IDLE, counts 0, ORIDX_o 0, ODST_o 0, OVALID_o 0, BUSY_o 0, OVF_o 0, OWord 0; data stores need no reset.
REQ-029 Reset mid-COLLECT or mid-DRAIN abandons the tile; no partial word emitted after release.

Structure
REQ-030 Shared package holds the FSM state encoding, ARRAY_DIM=4, and the ORIDX/ODST widths shared with the input buffer.
REQ-031 One sub-module, obuffer_col: single-column 4-entry store with counter, write strobe, full flag and row-select read port; instantiated 4 times.

Verification
REQ-032 Skewed tile: column j valid on cycles j..j+3, lane value = 0x10*row+col, OREADY_i=1 -> words 0x00010203, 0x10111213, 0x20212223, 0x30313233, ORIDX 0..3, first at cycle 8.
REQ-033 Backpressure: OREADY_i low 3 cycles on row 1 -> OWord/ORIDX_o held at 0x10111213/1, no loss, no duplicate.
REQ-034 Tag: ODST_i=0xA at first capture, 0x5 afterwards -> ODST_o=0xA on all four words.
REQ-035 Overflow: extra OCOL_VALID[2] during DRAIN -> OVF_o=1 and stays 1; drained words unchanged.
REQ-036 Reset after row 1 transfer -> OVALID_o=0, BUSY_o=0; next tile drains from ORIDX 0 with correct data.
REQ-037 Back-to-back tiles: second tile's column 0 begins cycle after last transfer -> both tiles emitted intact, OVF_o=0.

Source files
------------

// File: rtl/obuffer_deskew_pkg.sv
// Shared definitions for the output-buffer deskew block and its column stores.
package obuffer_deskew_pkg;

  // Systolic array edge length: columns per row and rows per tile.
  localparam int unsigned ARRAY_DIM = 4;
  // Row index and destination tag widths, shared with the input buffer.
  localparam int unsigned ORIDX_W   = 2;
  localparam int unsigned ODST_W    = 4;
  // Column fill counter must be able to hold ARRAY_DIM itself.
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2
  } state_e;

endpackage

// File: rtl/obuffer_deskew_if.sv
// Bus between the array bottom edge / downstream sink and the deskew block.
interface obuffer_deskew_if #(
  parameter int unsigned LANE_W = 8
);
  import obuffer_deskew_pkg::*;

  logic [ARRAY_DIM-1:0]        OCOL_VALID;
  logic [ARRAY_DIM*LANE_W-1:0] OROW_i;
  logic [ODST_W-1:0]           ODST_i;
  logic                        OREADY_i;
  logic [ARRAY_DIM*LANE_W-1:0] OWord;
  logic                        OVALID_o;
  logic [ORIDX_W-1:0]          ORIDX_o;
  logic [ODST_W-1:0]           ODST_o;
  logic                        BUSY_o;
  logic                        OVF_o;

  // Environment side: array strobes/data, tag and sink ready.
  modport master (
    output OCOL_VALID, OROW_i, ODST_i, OREADY_i,
    input  OWord, OVALID_o, ORIDX_o, ODST_o, BUSY_o, OVF_o
  );

  // Deskew block side.
  modport slave (
    input  OCOL_VALID, OROW_i, ODST_i, OREADY_i,
    output OWord, OVALID_o, ORIDX_o, ODST_o, BUSY_o, OVF_o
  );

endinterface

// File: rtl/obuffer_col.sv
// Single-column row store: captures up to ARRAY_DIM lanes in arrival order.
module obuffer_col
  import obuffer_deskew_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               wr_i,
  input  logic               clr_i,
  input  logic [LANE_W-1:0]  din_i,
  input  logic [ORIDX_W-1:0] rsel_i,
  output logic [LANE_W-1:0]  dout_o,
  output logic               full_o
);

  logic [LANE_W-1:0] mem_q [ARRAY_DIM];
  logic [CNT_W-1:0]  count_q;
  logic              wr_en;

  assign full_o = (count_q == CNT_W'(ARRAY_DIM));
  // A write into a full column is ignored even if the caller lets one through.
  assign wr_en  = wr_i & ~full_o;
  assign dout_o = mem_q[rsel_i];

  // Fill counter: the n-th capture lands in row n-1; cleared when the tile drains.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Data store, no reset needed: output is gated until the tile is complete.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[count_q[ORIDX_W-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/obuffer_deskew.sv
// Collects a skewed 4x4 tile column by column and drains it as aligned rows.
module obuffer_deskew
  import obuffer_deskew_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input logic             CLK,
  input logic             RSTN,
  obuffer_deskew_if.slave bus
);

  state_e               state_q;
  logic                 ovalid_q;
  logic                 busy_q;
  logic                 ovf_q;
  logic [ORIDX_W-1:0]   oridx_q;
  logic [ODST_W-1:0]    odst_q;

  logic [ARRAY_DIM-1:0] col_ok;
  logic [ARRAY_DIM-1:0] col_wr;
  logic [ARRAY_DIM-1:0] col_bad;
  logic [ARRAY_DIM-1:0] col_full;
  logic [LANE_W-1:0]    col_dout [ARRAY_DIM];
  logic [ARRAY_DIM*LANE_W-1:0] word;
  logic                 xfer;
  logic                 last_xfer;

  assign xfer      = ovalid_q & bus.OREADY_i;
  assign last_xfer = xfer & (oridx_q == ORIDX_W'(ARRAY_DIM - 1));

  // Column acceptance: only column 0 opens a tile, nothing is taken while draining.
  always_comb begin
    col_ok = '0;
    for (int j = 0; j < ARRAY_DIM; j++) begin
      case (state_q)
        StIdle:    col_ok[j] = (j == 0) && !col_full[j];
        StCollect: col_ok[j] = !col_full[j];
        default:   col_ok[j] = 1'b0;
      endcase
    end
    col_wr  = bus.OCOL_VALID & col_ok;
    col_bad = bus.OCOL_VALID & ~col_ok;
  end

  for (genvar j = 0; j < ARRAY_DIM; j++) begin : g_col
    obuffer_col #(
      .LANE_W(LANE_W)
    ) u_col (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .wr_i   (col_wr[j]),
      .clr_i  (last_xfer),
      .din_i  (bus.OROW_i[(ARRAY_DIM-j)*LANE_W-1 -: LANE_W]),
      .rsel_i (oridx_q),
      .dout_o (col_dout[j]),
      .full_o (col_full[j])
    );
  end

  // Output row assembly, column 0 in the MSB lane; zero whenever no word is offered.
  always_comb begin
    word = '0;
    for (int j = 0; j < ARRAY_DIM; j++) begin
      word[(ARRAY_DIM-j)*LANE_W-1 -: LANE_W] = ovalid_q ? col_dout[j] : '0;
    end
  end

  // Tile FSM with registered status outputs; any rejected strobe sets the sticky error.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      oridx_q  <= '0;
      odst_q   <= '0;
    end else begin
      if (|col_bad) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (bus.OCOL_VALID[0]) begin
            state_q <= StCollect;
            busy_q  <= 1'b1;
            odst_q  <= bus.ODST_i;
          end
        end
        StCollect: begin
          if (&col_full) begin
            state_q  <= StDrain;
            ovalid_q <= 1'b1;
            oridx_q  <= '0;
          end
        end
        StDrain: begin
          if (last_xfer) begin
            state_q  <= StIdle;
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
            oridx_q  <= '0;
          end else if (xfer) begin
            oridx_q <= oridx_q + ORIDX_W'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          ovalid_q <= 1'b0;
          busy_q   <= 1'b0;
          oridx_q  <= '0;
        end
      endcase
    end
  end

  assign bus.OWord    = word;
  assign bus.OVALID_o = ovalid_q;
  assign bus.ORIDX_o  = oridx_q;
  assign bus.ODST_o   = odst_q;
  assign bus.BUSY_o   = busy_q;
  assign bus.OVF_o    = ovf_q;

endmodule

// File: tb/tb_obuffer_deskew.sv
// Directed-sequence bench for obuffer_deskew with randomized tile contents.
module tb_obuffer_deskew;

  localparam int LW = 8;

  logic CLK;
  logic RSTN;
  int   checks;
  int   failures;
  bit   ovf_model;
  logic [LW-1:0] tile_d [4][4];

  obuffer_deskew_if #(.LANE_W(LW)) bus ();

  obuffer_deskew #(
    .LANE_W(LW)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tile_d[r][c] = LW'($urandom_range(0, 255));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ovalid"}, 32'(bus.OVALID_o), 32'd0);
    check({tag, ".busy"},   32'(bus.BUSY_o),   32'd0);
    check({tag, ".oword"},  bus.OWord,         32'd0);
    check({tag, ".ovf"},    32'(bus.OVF_o),    32'(ovf_model));
  endtask

  // Drive one skewed tile (column j valid on cycles j..j+3) and check every cycle
  // against the row-major model. Returns after stop_after transfers.
  task automatic run_tile(input string tag, input logic [3:0] tag0, input logic [3:0] tag1,
                          input int stall_lo, input int stall_hi,
                          input int inj_c, input int inj_col, input int stop_after);
    logic [31:0] exp_w [4];
    logic [3:0]  v;
    logic [31:0] row;
    int          c;
    int          xfers;
    bit          exp_valid;
    for (int r = 0; r < 4; r++)
      exp_w[r] = {tile_d[r][0], tile_d[r][1], tile_d[r][2], tile_d[r][3]};
    c = 0;
    xfers = 0;
    while (xfers < stop_after && c < 60) begin
      v   = '0;
      row = '0;
      for (int j = 0; j < 4; j++) begin
        if (c >= j && c <= j + 3) begin
          v[j] = 1'b1;
          row[(4-j)*LW-1 -: LW] = tile_d[c-j][j];
        end
      end
      if (c == inj_c) begin
        v[inj_col] = 1'b1;
        row[(4-inj_col)*LW-1 -: LW] = 8'hEE;
      end
      bus.OCOL_VALID = v;
      bus.OROW_i     = row;
      bus.ODST_i     = (c == 0) ? tag0 : tag1;
      bus.OREADY_i   = !(c >= stall_lo && c <= stall_hi);
      // Last capture lands at the end of cycle 6; row 0 is offered from cycle 8.
      exp_valid = (c >= 8);
      check($sformatf("%s.c%0d.ovalid", tag, c), 32'(bus.OVALID_o), 32'(exp_valid));
      check($sformatf("%s.c%0d.busy", tag, c), 32'(bus.BUSY_o), 32'(c >= 1));
      check($sformatf("%s.c%0d.ovf", tag, c), 32'(bus.OVF_o), 32'(ovf_model));
      if (c >= 1)
        check($sformatf("%s.c%0d.odst", tag, c), 32'(bus.ODST_o), 32'(tag0));
      if (exp_valid) begin
        check($sformatf("%s.c%0d.oword", tag, c), bus.OWord, exp_w[xfers]);
        check($sformatf("%s.c%0d.oridx", tag, c), 32'(bus.ORIDX_o), 32'(xfers));
      end else begin
        check($sformatf("%s.c%0d.oword0", tag, c), bus.OWord, 32'd0);
      end
      if (c == inj_c) ovf_model = 1'b1;
      if (exp_valid && bus.OREADY_i) xfers++;
      tick();
      c++;
    end
    check({tag, ".timeout"}, 32'(xfers >= stop_after), 32'd1);
    bus.OCOL_VALID = '0;
    bus.OROW_i     = '0;
    bus.OREADY_i   = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    ovf_model = 1'b0;
    RSTN           = 1'b0;
    bus.OCOL_VALID = '0;
    bus.OROW_i     = '0;
    bus.ODST_i     = '0;
    bus.OREADY_i   = 1'b1;

    // Reset state
    #3;
    check_idle("reset");
    check("reset.oridx", 32'(bus.ORIDX_o), 32'd0);
    check("reset.odst",  32'(bus.ODST_o),  32'd0);
    tick();
    tick();
    RSTN = 1'b1;
    tick();
    check_idle("post_reset");

    // Reference skewed tile: lane = 0x10*row + col
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tile_d[r][c] = LW'(16 * r + c);
    run_tile("skew", 4'h3, 4'h3, 100, 100, -1, 0, 4);
    check_idle("skew.end");
    tick();

    // Backpressure on row 1 plus tag latched only at first capture
    fill_random();
    run_tile("bp", 4'hA, 4'h5, 9, 11, -1, 0, 4);
    check_idle("bp.end");
    check("bp.odst_kept", 32'(bus.ODST_o), 32'hA);
    tick();

    // Stray column-2 strobe during drain
    fill_random();
    run_tile("ovf", 4'h7, 4'h7, 100, 100, 9, 2, 4);
    tick();
    tick();
    check_idle("ovf.sticky");

    // Stray column-1 strobe while idle
    bus.OCOL_VALID = 4'b0010;
    bus.OROW_i     = 32'hFFFF_FFFF;
    tick();
    bus.OCOL_VALID = '0;
    check_idle("idle_stray");

    // Reset after row 1 transfer abandons the tile and clears the error
    fill_random();
    run_tile("abort", 4'hC, 4'hC, 100, 100, -1, 0, 2);
    RSTN = 1'b0;
    ovf_model = 1'b0;
    #2;
    check_idle("abort.rst");
    check("abort.rst.oridx", 32'(bus.ORIDX_o), 32'd0);
    tick();
    RSTN = 1'b1;
    tick();
    check_idle("abort.released");
    fill_random();
    run_tile("after_abort", 4'h9, 4'h1, 100, 100, -1, 0, 4);
    check_idle("after_abort.end");

    // Back-to-back tiles with no idle gap between them
    fill_random();
    run_tile("b2b0", 4'h2, 4'h4, 100, 100, -1, 0, 4);
    fill_random();
    run_tile("b2b1", 4'hE, 4'h0, 10, 10, -1, 0, 4);
    check_idle("b2b.end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
